// File: rtl/seq_table_controller.sv
// Table-driven sequencer: steps count_out through a host-loaded table on each adv strobe.
// Optional sticky command-error flag (err) is built in when SEQ_TABLE_CTRL_ERR_EN is defined.
module seq_table_controller #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic              adv,
    output logic [WIDTH-1:0]  count_out,
    output logic [ADDR_W-1:0] index,
    output logic              busy,
    output logic              done,
    output logic              wrap
`ifdef SEQ_TABLE_CTRL_ERR_EN
    ,
    output logic              err
`endif
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  table_q [DEPTH];
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d, idx_inc;
    logic [ADDR_W:0]   len_q, len_d;
    logic              loop_q, loop_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;
    logic              idle_like, len_ok, start_ok, wr_ok, last;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign len_ok    = (seq_len != '0) && (seq_len <= DEPTH_L);
    assign start_ok  = start && len_ok && idle_like;
    assign wr_ok     = wr_en && idle_like && ({1'b0, wr_addr} < DEPTH_L);
    assign idx_inc   = idx_q + 1'b1;
    assign last      = ({1'b0, idx_q} == (len_q - 1'b1));

    // Table reads in the start cycle see the pre-write contents because the write is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else if (wr_ok) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d = RUN;
                    idx_d   = '0;
                    cnt_d   = table_q[0];
                    len_d   = seq_len;
                    loop_d  = loop_en;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (adv) begin
                    if (last) begin
                        if (loop_q) begin
                            idx_d  = '0;
                            cnt_d  = table_q[0];
                            wrap_d = 1'b1;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_inc;
                        cnt_d = table_q[idx_inc];
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_out = cnt_q;
    assign index     = idx_q;
    assign busy      = (state_q == RUN) || (state_q == PAUSE);
    assign done      = done_q;
    assign wrap      = wrap_q;

`ifdef SEQ_TABLE_CTRL_ERR_EN
    logic err_q, err_d;

    // Only an accepted start clears the flag; every rejected command sets it.
    always_comb begin
        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end else if ((!idle_like && (wr_en || start)) || (start && !len_ok)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_seq_table_controller.sv
// Bench for seq_table_controller: directed scenarios plus randomized commands against a
// behavioural model of the sequencer (run mode, position, latched length/loop, table).
module tb_seq_table_controller;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] seq_len;
    logic       start, stop, pause, loop_en, adv;
    logic [3:0] count_out;
    logic [2:0] index;
    logic       busy, done, wrap;
`ifdef SEQ_TABLE_CTRL_ERR_EN
    logic       err;
`endif

    int tot = 0;
    int bad = 0;

    // Model: mode 0=idle 1=run 2=pause 3=finished
    int m_tbl [8];
    int m_mode, m_pos, m_len, m_cnt;
    bit m_loop, m_done, m_wrap, m_err;

    seq_table_controller #(.WIDTH(4), .DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .seq_len(seq_len), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
        .adv(adv), .count_out(count_out), .index(index), .busy(busy), .done(done),
        .wrap(wrap)
`ifdef SEQ_TABLE_CTRL_ERR_EN
        , .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_tbl[i] = 0;
        m_mode = 0; m_pos = 0; m_len = 0; m_cnt = 0;
        m_loop = 0; m_done = 0; m_wrap = 0; m_err = 0;
    endfunction

    function automatic logic [9:0] exp_vec();
        return {4'(m_cnt), 3'(m_pos), (m_mode == 1 || m_mode == 2), m_done, m_wrap};
    endfunction

    // Drive one cycle of inputs, clock them in, advance the model, settle.
    task automatic step(input bit we, input int wa, input int wd, input int sl, input bit st,
                        input bit sp, input bit ps, input bit lp, input bit ad);
        bit stopped, ok_len, accept;
        int first;
        wr_en = we; wr_addr = wa[2:0]; wr_data = wd[3:0]; seq_len = sl[3:0];
        start = st; stop = sp; pause = ps; loop_en = lp; adv = ad;
        @(posedge clk);
        stopped = (m_mode == 0 || m_mode == 3);
        ok_len  = (sl >= 1 && sl <= 8);
        accept  = st && ok_len && stopped;
        first   = m_tbl[0];
        m_done = 0; m_wrap = 0;
        if (accept) m_err = 0;
        else if ((!stopped && (we || st)) || (st && !ok_len)) m_err = 1;
        if (we && stopped && wa < 8) m_tbl[wa] = wd;
        if (stopped) begin
            if (accept) begin
                m_mode = 1; m_pos = 0; m_cnt = first; m_len = sl; m_loop = lp;
            end
        end else if (sp) begin
            m_mode = 0; m_pos = 0; m_cnt = 0;
        end else if (m_mode == 2) begin
            if (!ps) m_mode = 1;
        end else if (ps) begin
            m_mode = 2;
        end else if (ad) begin
            if (m_pos + 1 < m_len) begin
                m_pos++; m_cnt = m_tbl[m_pos];
            end else if (m_loop) begin
                m_pos = 0; m_cnt = m_tbl[0]; m_wrap = 1;
            end else begin
                m_mode = 3; m_done = 1;
            end
        end
        #1;
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; seq_len = 0;
        start = 0; stop = 0; pause = 0; loop_en = 0; adv = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tot++;
        if ({count_out, index, busy, done, wrap} !== 10'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=0", {count_out, index, busy, done, wrap});
        end
`ifdef SEQ_TABLE_CTRL_ERR_EN
        tot++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
`endif
        reset = 1'b1;
        idle_cycle();
        tot++;
        if ({count_out, busy} !== 5'b0) begin
            bad++; $display("FAIL post_reset_idle got=%b want=0", {count_out, busy});
        end
    endtask

    task automatic test_single_run();
        int vals [5] = '{3, 5, 9, 12, 15};
        int expc [5] = '{5, 9, 12, 15, 15};
        for (int i = 0; i < 5; i++) step(1, i, vals[i], 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 5, 1, 0, 0, 0, 0);
        tot++;
        if (count_out !== 4'd3 || busy !== 1'b1) begin
            bad++; $display("FAIL start_first count=%0d busy=%b want 3/1", count_out, busy);
        end
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1);
            tot++;
            if (count_out !== 4'(expc[k]) || done !== (k == 4) || busy !== (k != 4)) begin
                bad++;
                $display("FAIL single_step%0d count=%0d done=%b busy=%b want %0d/%b/%b",
                         k, count_out, done, busy, expc[k], k == 4, k != 4);
            end
        end
        idle_cycle();
        tot++;
        if (count_out !== 4'd15 || done !== 1'b0 || busy !== 1'b0 || index !== 3'd4) begin
            bad++; $display("FAIL done_hold count=%0d done=%b busy=%b idx=%0d want 15/0/0/4",
                            count_out, done, busy, index);
        end
    endtask

    task automatic test_loop();
        int vals [5] = '{3, 5, 9, 12, 15};
        step(0, 0, 0, 5, 1, 0, 0, 1, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1);
            tot++;
            if (count_out !== 4'(vals[(k + 1) % 5]) || wrap !== ((k + 1) % 5 == 0) || done !== 1'b0) begin
                bad++;
                $display("FAIL loop_step%0d count=%0d wrap=%b done=%b want %0d/%b/0",
                         k, count_out, wrap, done, vals[(k + 1) % 5], (k + 1) % 5 == 0);
            end
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_pause();
        step(0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0, 1);
            tot++;
            if (count_out !== 4'd9 || index !== 3'd2 || busy !== 1'b1) begin
                bad++; $display("FAIL pause_hold%0d count=%0d idx=%0d busy=%b want 9/2/1",
                                k, count_out, index, busy);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tot++;
        if (count_out !== 4'd9) begin
            bad++; $display("FAIL pause_return count=%0d want 9", count_out);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tot++;
        if (count_out !== 4'd12 || index !== 3'd3) begin
            bad++; $display("FAIL pause_resume count=%0d idx=%0d want 12/3", count_out, index);
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_stop();
        step(0, 0, 0, 5, 1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tot++;
        if (count_out !== 4'd12 || index !== 3'd3) begin
            bad++; $display("FAIL stop_setup count=%0d idx=%0d want 12/3", count_out, index);
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        tot++;
        if ({count_out, index, busy, done} !== 9'b0) begin
            bad++; $display("FAIL stop_abort got=%b want=0", {count_out, index, busy, done});
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        tot++;
        if ({count_out, busy, done} !== 6'b0) begin
            bad++; $display("FAIL stop_idle got=%b want=0", {count_out, busy, done});
        end
    endtask

    task automatic test_busy_ignore();
        step(0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 7, 3, 1, 0, 0, 0, 0);
        tot++;
        if (count_out !== 4'd5 || index !== 3'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL busy_cmd count=%0d idx=%0d busy=%b want 5/1/1", count_out, index, busy);
        end
`ifdef SEQ_TABLE_CTRL_ERR_EN
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        tot++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
`else
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
`endif
        step(0, 0, 0, 5, 1, 0, 0, 0, 0);
`ifdef SEQ_TABLE_CTRL_ERR_EN
        tot++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
`endif
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tot++;
        if (count_out !== 4'd5) begin
            bad++; $display("FAIL busy_write_blocked count=%0d want 5", count_out);
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_bad_len();
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tot++;
        if (busy !== 1'b0 || count_out !== 4'd0) begin
            bad++; $display("FAIL len0 busy=%b count=%0d want 0/0", busy, count_out);
        end
        step(0, 0, 0, 9, 1, 0, 0, 0, 0);
        tot++;
        if (busy !== 1'b0 || count_out !== 4'd0) begin
            bad++; $display("FAIL len9 busy=%b count=%0d want 0/0", busy, count_out);
        end
`ifdef SEQ_TABLE_CTRL_ERR_EN
        tot++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_badlen got=%b want=1", err); end
`endif
    endtask

    task automatic test_write_with_start();
        step(1, 0, 11, 5, 1, 0, 0, 0, 0);
        tot++;
        if (count_out !== 4'd3) begin
            bad++; $display("FAIL start_prewrite count=%0d want 3", count_out);
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 5, 1, 0, 0, 0, 0);
        tot++;
        if (count_out !== 4'd11) begin
            bad++; $display("FAIL start_postwrite count=%0d want 11", count_out);
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_len1_loop();
        step(0, 0, 0, 1, 1, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1);
            tot++;
            if (count_out !== 4'd3 || wrap !== 1'b1 || index !== 3'd0 || done !== 1'b0) begin
                bad++; $display("FAIL len1_loop%0d count=%0d wrap=%b idx=%0d done=%b want 3/1/0/0",
                                k, count_out, wrap, index, done);
            end
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 15),
                 $urandom_range(0, 9), $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
            tot++;
            if ({count_out, index, busy, done, wrap} !== exp_vec()) begin
                bad++; $display("FAIL random_cycle%0d got=%b want=%b", n,
                                {count_out, index, busy, done, wrap}, exp_vec());
            end
`ifdef SEQ_TABLE_CTRL_ERR_EN
            tot++;
            if (err !== m_err) begin
                bad++; $display("FAIL random_err%0d got=%b want=%b", n, err, m_err);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        int vals [5] = '{3, 5, 9, 12, 15};
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, i, vals[i], 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 8, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2 reset = 1'b0;
        #1;
        tot++;
        if ({count_out, index, busy, done, wrap} !== 10'b0) begin
            bad++; $display("FAIL async_reset got=%b want=0", {count_out, index, busy, done, wrap});
        end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        step(0, 0, 0, 8, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1);
            tot++;
            if (count_out !== 4'd0 || done !== (k == 7)) begin
                bad++; $display("FAIL table_cleared%0d count=%0d done=%b want 0/%b",
                                k, count_out, done, k == 7);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_loop();
        test_pause();
        test_stop();
        test_busy_ignore();
        test_bad_len();
        test_write_with_start();
        test_len1_loop();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
